// File: rtl/ray_pkg.sv
// Shared raycaster types: Q6.10 fixed point and the delta-setup FSM states.
package ray_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;

  typedef logic signed [DATA_W-1:0] q6_10_t;

  localparam logic [DATA_W-1:0] Q_ONE = 16'h0400;
  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC_X,
    ST_CALC_Y,
    ST_DONE
  } ray_state_t;
endpackage

// File: rtl/ray_delta_setup_if.sv
// Ray-direction in / DDA-delta out handshake bundle for ray_delta_setup.
interface ray_delta_setup_if;
  import ray_pkg::*;

  logic                i_valid;
  logic                o_ready;
  q6_10_t              i_ray_dx;
  q6_10_t              i_ray_dy;
  logic                o_valid;
  logic                i_ready;
  logic [DATA_W-1:0]   o_delta_x;
  logic [DATA_W-1:0]   o_delta_y;
  logic                o_step_x_neg;
  logic                o_step_y_neg;
  logic                o_sat_x;
  logic                o_sat_y;

  modport slave (
    input  i_valid, i_ray_dx, i_ray_dy, i_ready,
    output o_ready, o_valid, o_delta_x, o_delta_y,
           o_step_x_neg, o_step_y_neg, o_sat_x, o_sat_y
  );

  modport master (
    output i_valid, i_ray_dx, i_ray_dy, i_ready,
    input  o_ready, o_valid, o_delta_x, o_delta_y,
           o_step_x_neg, o_step_y_neg, o_sat_x, o_sat_y
  );
endinterface

// File: rtl/reciprocal.sv
// Combinational Q6.10 reciprocal: floor(2^20 / x), saturating at Q_MAX; x = 0 yields Q_MAX.
module reciprocal import ray_pkg::*; (
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result
);
  // 1.0 * 1.0 in Q12.20 so the quotient lands back in Q6.10
  localparam logic [20:0] NUMER = 21'h100000;

  logic [20:0] quot;

  always_comb begin
    quot = '1;
    if (operand != '0) quot = NUMER / {5'd0, operand};
    result = (quot > {5'd0, Q_MAX}) ? Q_MAX : quot[DATA_W-1:0];
  end
endmodule

// File: rtl/ray_delta_setup.sv
// Per-ray DDA setup: |1/dx|, |1/dy| and step signs, sharing one reciprocal across both axes.
module ray_delta_setup import ray_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  ray_delta_setup_if.slave bus
);
  ray_state_t state, state_nxt;

  q6_10_t            dx_p0, dy_p0;
  logic [DATA_W-1:0] abs_x, abs_y, recip_in, recip_out;
  logic              zero_sel;
  logic              accept;

  logic [DATA_W-1:0] delta_x_p1, delta_y_p1;
  logic              sat_x_p1, sat_y_p1;
  logic              step_x_neg_p0, step_y_neg_p0;
  logic              vld_p1;

  // Magnitude with -32768 folded onto +32767 so it always fits the positive range
  function automatic logic [DATA_W-1:0] abs_clamp(input q6_10_t v);
    logic [DATA_W-1:0] mag;
    if (v == 16'sh8000)
      mag = Q_MAX;
    else if (v[DATA_W-1])
      mag = DATA_W'(-v);
    else
      mag = DATA_W'(v);
    return mag;
  endfunction

  function automatic logic [DATA_W-1:0] sat_delta(input logic zero, input logic [DATA_W-1:0] r);
    return zero ? Q_MAX : r;
  endfunction

  function automatic logic sat_flag(input logic zero, input logic [DATA_W-1:0] r);
    return zero || (r == Q_MAX);
  endfunction

  assign bus.o_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.i_ready);
  assign accept      = bus.i_valid && bus.o_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_CALC_X;
      ST_CALC_X: state_nxt = ST_CALC_Y;
      ST_CALC_Y: state_nxt = ST_DONE;
      ST_DONE:   if (bus.i_ready) state_nxt = accept ? ST_CALC_X : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: operand prep and the shared reciprocal
  assign abs_x    = abs_clamp(dx_p0);
  assign abs_y    = abs_clamp(dy_p0);
  assign recip_in = (state == ST_CALC_Y) ? abs_y : abs_x;
  assign zero_sel = (recip_in == '0);

  reciprocal u_recip (
    .operand (recip_in),
    .result  (recip_out)
  );

  // Stage p1: capture and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dx_p0         <= '0;
      dy_p0         <= '0;
      step_x_neg_p0 <= 1'b0;
      step_y_neg_p0 <= 1'b0;
      delta_x_p1    <= '0;
      delta_y_p1    <= '0;
      sat_x_p1      <= 1'b0;
      sat_y_p1      <= 1'b0;
      vld_p1        <= 1'b0;
    end else begin
      vld_p1 <= (state_nxt == ST_DONE);
      if (accept) begin
        dx_p0         <= bus.i_ray_dx;
        dy_p0         <= bus.i_ray_dy;
        step_x_neg_p0 <= bus.i_ray_dx[DATA_W-1];
        step_y_neg_p0 <= bus.i_ray_dy[DATA_W-1];
      end
      if (state == ST_CALC_X) begin
        delta_x_p1 <= sat_delta(zero_sel, recip_out);
        sat_x_p1   <= sat_flag(zero_sel, recip_out);
      end
      if (state == ST_CALC_Y) begin
        delta_y_p1 <= sat_delta(zero_sel, recip_out);
        sat_y_p1   <= sat_flag(zero_sel, recip_out);
      end
    end
  end

  assign bus.o_valid      = vld_p1;
  assign bus.o_delta_x    = delta_x_p1;
  assign bus.o_delta_y    = delta_y_p1;
  assign bus.o_step_x_neg = step_x_neg_p0;
  assign bus.o_step_y_neg = step_y_neg_p0;
  assign bus.o_sat_x      = sat_x_p1;
  assign bus.o_sat_y      = sat_y_p1;
endmodule

// File: tb/tb_ray_delta_setup.sv
// Scoreboard bench for ray_delta_setup: directed vectors, backpressure, reset abort, random stream.
module tb_ray_delta_setup;
  typedef struct packed {
    logic [15:0] dx_d;
    logic [15:0] dy_d;
    logic        xn;
    logic        yn;
    logic        sx;
    logic        sy;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   ready_mode = 0;
  res_t exp_q[$];

  ray_delta_setup_if bus();

  ray_delta_setup dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  // Reference: delta = floor(1.0 / |c|) in Q6.10, capped at 32767 (|c| itself capped at 32767)
  function automatic void axis(input logic [15:0] c, output logic [15:0] d,
                               output logic neg, output logic sat);
    int v, a, q;
    v   = int'($signed(c));
    neg = (v < 0);
    a   = neg ? -v : v;
    if (a > 32767) a = 32767;
    if (a == 0) begin
      d = 16'h7FFF; sat = 1'b1;
    end else begin
      q = 1048576 / a;
      if (q >= 32767) begin d = 16'h7FFF; sat = 1'b1; end
      else begin d = 16'(q); sat = 1'b0; end
    end
  endfunction

  function automatic res_t model(input logic [15:0] dx, input logic [15:0] dy);
    res_t r;
    axis(dx, r.dx_d, r.xn, r.sx);
    axis(dy, r.dy_d, r.yn, r.sy);
    return r;
  endfunction

  function automatic res_t cur_out();
    res_t r;
    r.dx_d = bus.o_delta_x;
    r.dy_d = bus.o_delta_y;
    r.xn   = bus.o_step_x_neg;
    r.yn   = bus.o_step_y_neg;
    r.sx   = bus.o_sat_x;
    r.sy   = bus.o_sat_y;
    return r;
  endfunction

  function automatic logic [15:0] rand_comp();
    logic [15:0] s;
    case ($urandom_range(0, 9))
      0:       s = 16'h0000;
      1:       s = 16'h8000;
      2, 3:    s = 16'($urandom_range(0, 80)) - 16'd40;
      default: s = 16'($urandom);
    endcase
    return s;
  endfunction

  // Offers one ray; at the accepting edge pushes exp when push is set. Returns at posedge+1.
  task automatic send_ray(input logic [15:0] dx, input logic [15:0] dy, input bit push,
                          input res_t e, output int waits);
    waits = 0;
    bus.i_valid  = 1'b1;
    bus.i_ray_dx = dx;
    bus.i_ray_dy = dy;
    forever begin
      @(negedge clk);
      if (bus.o_ready) break;
      waits++;
      if (waits > 50) begin
        checks++; failures++;
        $display("FAIL accept_timeout got=no_ready want=ready");
        break;
      end
    end
    if (push && waits <= 50) exp_q.push_back(e);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  // Called right after the accepting edge: o_valid low for two samples then high
  task automatic check_latency(input string name);
    @(negedge clk); chk({name, "_lat1"}, 64'(bus.o_valid), 64'(0));
    @(negedge clk); chk({name, "_lat2"}, 64'(bus.o_valid), 64'(0));
    @(negedge clk); chk({name, "_lat3"}, 64'(bus.o_valid), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  // Downstream ready driver
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = ($urandom_range(0, 3) != 0);
        default: bus.i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on every output handshake, checks stability while stalled
  initial begin
    res_t held, e;
    bit   held_v = 0;
    forever begin
      @(negedge clk);
      if (reset) held_v = 0;
      else begin
        if (held_v && bus.o_valid) chk("hold_stable", 64'(cur_out()), 64'(held));
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output got=%h want=none", cur_out());
          end else begin
            e = exp_q.pop_front();
            chk("result", 64'(cur_out()), 64'(e));
          end
          held_v = 0;
        end else if (bus.o_valid) begin
          held_v = 1; held = cur_out();
        end else held_v = 0;
      end
    end
  end

  initial begin
    int   w;
    res_t cap;
    bus.i_valid  = 1'b0;
    bus.i_ray_dx = '0;
    bus.i_ray_dy = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_valid", 64'(bus.o_valid), 64'(0));
    chk("rst_ready", 64'(bus.o_ready), 64'(1));
    chk("rst_outputs", 64'(cur_out()), 64'(0));
    @(posedge clk); #1;

    send_ray(16'h0400, 16'h0800, 1, '{16'h0400, 16'h0200, 0, 0, 0, 0}, w);
    check_latency("vec_1_2");
    drain("vec_1_2");

    send_ray(16'hFE00, 16'hFC00, 1, '{16'h0800, 16'h0400, 1, 1, 0, 0}, w);
    check_latency("vec_neg");
    drain("vec_neg");

    send_ray(16'h0000, 16'h8000, 1, '{16'h7FFF, 16'h0020, 0, 1, 1, 0}, w);
    check_latency("vec_zero_min");
    drain("vec_zero_min");

    // Small magnitudes overflow the reciprocal
    send_ray(16'h0001, 16'hFFE0, 1, '{16'h7FFF, 16'h7FFF, 0, 1, 1, 1}, w);
    drain("vec_ovf");

    // Backpressure in DONE, then release with a new ray in the same cycle
    ready_mode = 2;
    send_ray(16'h0C00, 16'hF400, 1, model(16'h0C00, 16'hF400), w);
    w = 0;
    while (!bus.o_valid && w < 20) begin @(negedge clk); w++; end
    chk("bp_reached_done", 64'(bus.o_valid), 64'(1));
    cap = cur_out();
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", 64'(cur_out()), 64'(cap));
      chk("bp_ready_low", 64'(bus.o_ready), 64'(0));
    end
    @(posedge clk); #1;
    ready_mode = 0;
    send_ray(16'h1234, 16'hEDCC, 1, model(16'h1234, 16'hEDCC), w);
    chk("bp_same_cycle_accept", 64'(w), 64'(0));
    check_latency("bp_next");
    drain("bp");

    // Reset during CALC_Y discards the ray
    send_ray(16'h0400, 16'h0400, 0, '0, w);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(bus.o_valid), 64'(0));
    chk("abort_ready", 64'(bus.o_ready), 64'(1));
    chk("abort_outputs", 64'(cur_out()), 64'(0));
    repeat (4) @(negedge clk);
    chk("abort_no_result", 64'(bus.o_valid), 64'(0));
    @(posedge clk); #1;

    ready_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] rx, ry;
      rx = rand_comp();
      ry = rand_comp();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_ray(rx, ry, 1, model(rx, ry), w);
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ray_delta_setup.md
# ray_delta_setup

Per-ray setup stage for the raycaster DDA. Accepts one ray direction vector (dx, dy) in signed Q6.10 and produces the DDA step deltas |1/dx| and |1/dy| with per-axis step signs. It time-shares a single `reciprocal` instance across both axes under a small FSM. Valid/ready handshakes sit on both sides, between the ray-direction generator and the DDA stepper.

## Interface
- No parameters; format fixed at Q6.10 (16-bit, 10 fraction bits).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_valid`  in  1  upstream offers a ray direction.
- `o_ready`  out  1  block can accept a ray this cycle.
- `i_ray_dx`  in  16  signed Q6.10 ray direction X.
- `i_ray_dy`  in  16  signed Q6.10 ray direction Y.
- `o_valid`  out  1  result available.
- `i_ready`  in  1  downstream accepts result.
- `o_delta_x`  out  16  unsigned Q6.10 |1/dx|, max 0x7FFF.
- `o_delta_y`  out  16  unsigned Q6.10 |1/dy|, max 0x7FFF.
- `o_step_x_neg`  out  1  1 = dx negative (DDA steps −X).
- `o_step_y_neg`  out  1  1 = dy negative.
- `o_sat_x`  out  1  delta_x saturated (dx = 0 or reciprocal overflow).
- `o_sat_y`  out  1  delta_y saturated.

## Operation
- States: IDLE, CALC_X, CALC_Y, DONE.
- Accept: `i_valid && o_ready` captures dx, dy into input registers; sign bits go straight to the step-sign registers.
- `o_ready` = (state == IDLE) || (state == DONE && `i_ready`). A new ray is therefore accepted in the same cycle the old result is consumed.
- Operand preparation: abs value of the captured component. 0x8000 clamps to 0x7FFF before the reciprocal, so its abs cannot overflow.
- CALC_X: the reciprocal input mux selects |dx|; output is registered into `o_delta_x`. Next state is CALC_Y.
- CALC_Y: the mux selects |dy|; output is registered into `o_delta_y`. Next state is DONE.
- Zero component: the delta is forced to 0x7FFF and the sat flag is set, independent of the reciprocal output.
- Reciprocal output 0x7FFF for a nonzero input also sets the sat flag.
- The reciprocal is fed a positive operand only, so its result is non-negative and is used unmodified.
- DONE: `o_valid` = 1. Outputs are held stable until `i_ready`.
  - `i_ready` && `i_valid` → capture the new ray, go to CALC_X.
  - `i_ready` && !`i_valid` → go to IDLE.
  - !`i_ready` → stay in DONE.
- All outputs are registered except `o_ready`, which is combinational from state and `i_ready`.

## Timing
- Reset values:
  - state = IDLE, `o_valid` = 0, `o_ready` = 1 (combinational, from IDLE).
  - deltas = 0x0000, step signs = 0, sat flags = 0.
  - input registers cleared.
- Latency: accept at edge N → CALC_X after N, CALC_Y after N+1, DONE after N+2. `o_valid` is high in the cycle after edge N+2.
- Throughput: one ray per 3 cycles when downstream is always ready; no bubble between back-to-back rays.
- `o_delta_x` updates at edge N+1 while `o_valid` = 0. Downstream only samples when `o_valid` = 1.
- Handshake rules:
  - `i_valid` is ignored outside IDLE and DONE.
  - Upstream holds data until `o_ready`.
  - Downstream backpressure holds DONE indefinitely with no output change.
- Reset mid-operation (any state): the next edge returns to IDLE with all reset values. The in-flight ray is discarded; no partial result is presented.
- Reset has priority over a simultaneous handshake.

## Structure
- Shared package `ray_pkg`:
  - Q6.10 typedef (16-bit signed) and `Q_ONE` = 16'h0400, `Q_MAX` = 16'h7FFF.
  - State enum for this FSM.
- One sub-module: `reciprocal`, instanced once, combinational. It sits between the operand mux and the delta registers. This is the critical path.
- Local logic: abs/clamp, zero detect, operand mux, FSM, output registers.

## Test plan
- Reset then idle: `o_valid` = 0, `o_ready` = 1, all outputs 0. Assert `reset` for one cycle mid-CALC_Y → IDLE, `o_valid` stays 0.
- dx = 0x0400 (1.0), dy = 0x0800 (2.0), `i_ready` = 1 → 3 cycles later `o_delta_x` = 0x0400, `o_delta_y` = 0x0200, step signs 0/0, sat 0/0.
- dx = 0xFE00 (−0.5), dy = 0xFC00 (−1.0) → `o_delta_x` = 0x0800, `o_delta_y` = 0x0400, `o_step_x_neg` = 1, `o_step_y_neg` = 1.
- dx = 0x0000, dy = 0x8000 → `o_delta_x` = 0x7FFF, `o_sat_x` = 1. `o_delta_y` equals the reciprocal model of 0x7FFF, `o_step_y_neg` = 1.
- Backpressure: hold `i_ready` = 0 for 5 cycles in DONE → outputs stable, `o_ready` = 0. Release with `i_valid` = 1 → the new ray is accepted in the same cycle and the next `o_valid` follows 3 cycles later.
- Random stream of 1000 rays with random `i_valid`/`i_ready` → every result matches the bit-exact model, in order, none dropped or duplicated.
